skew_aligner: RTL and testbench

Receive-side companion to the delay stage: takes the original data stream (`ref_in`) and the same stream after an unknown fixed pipeline delay (`dly_in`). It measures the cycle skew between the two using a probe-match search. Once locked, it re-times `ref_in` through an internal history line so both streams leave the block cycle-aligned. It sits downstream of any delay or pipeline stage whose latency must be measured rather than trusted.

---
 rtl/skew_aligner_pkg.sv | 17 +
 rtl/skew_aligner_ref_history.sv | 54 +++++
 rtl/skew_aligner.sv | 159 +++++++++++++++
 tb/tb_skew_aligner.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/skew_aligner_pkg.sv
// ---------------------------------------------------------------------------
// skew_aligner_pkg
// Shared definitions for the skew aligner: measurement FSM state encoding and
// default stream width / maximum measurable skew.
// ---------------------------------------------------------------------------
package skew_aligner_pkg;

    localparam int DEFAULT_W        = 4;
    localparam int DEFAULT_MAX_SKEW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/skew_aligner_ref_history.sv
// ---------------------------------------------------------------------------
// ref_history
// W x MAX_SKEW shift register holding the recent past of the reference
// stream, with a skew-indexed combinational read port.
//   hist[i] holds ref_in delayed by i+1 cycles.
//   rd_skew == 0 returns ref_in itself (zero-delay bypass).
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset, clears the history
//   ref_in   in   W    reference stream sample for this cycle
//   rd_skew  in   SKW  delay to read back (0..MAX_SKEW)
//   rd_data  out  W    ref_in delayed by rd_skew cycles
// ---------------------------------------------------------------------------
module ref_history
    import skew_aligner_pkg::*;
#(
    parameter int W        = DEFAULT_W,
    parameter int MAX_SKEW = DEFAULT_MAX_SKEW,
    parameter int SKW      = $clog2(MAX_SKEW + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   ref_in,
    input  logic [SKW-1:0] rd_skew,
    output logic [W-1:0]   rd_data
);

    logic [W-1:0] hist [MAX_SKEW];

    // Shifts every cycle regardless of the measurement state
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_SKEW; i++) begin
                hist[i] <= '0;
            end
        end else begin
            hist[0] <= ref_in;
            for (int i = 1; i < MAX_SKEW; i++) begin
                hist[i] <= hist[i-1];
            end
        end
    end

    // Compare-based mux keeps the index in range for any rd_skew value
    always_comb begin
        rd_data = ref_in;
        for (int i = 0; i < MAX_SKEW; i++) begin
            if (rd_skew == SKW'(i + 1)) begin
                rd_data = hist[i];
            end
        end
    end

endmodule

// File: rtl/skew_aligner.sv
// ---------------------------------------------------------------------------
// skew_aligner
// Measures the fixed cycle skew between a reference stream and a delayed copy
// of it by latching a probe sample on start and counting cycles until the
// probe shows up on the delayed stream. Once locked, the reference stream is
// re-timed through a history line so both streams leave cycle-aligned.
//
// Optional feature: define SKEW_ALIGNER_LOSS_DETECT_EN to drop lock (with an
// err pulse) when the aligned pair disagrees while LOCKED. Without it, LOCKED
// is left only through start or rst.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   ref_in         in   W    undelayed stream
//   dly_in         in   W    delayed stream
//   start          in   request a measurement (ignored while searching)
//   busy           out  measurement in progress
//   locked         out  skew valid, alignment active
//   err            out  one-cycle pulse: search timeout / loss of lock
//   skew           out  SKW  measured skew in cycles
//   aligned_ref    out  W    ref_in delayed by skew, registered
//   aligned_dly    out  W    dly_in, registered
//   aligned_valid  out  aligned outputs meaningful
// ---------------------------------------------------------------------------
module skew_aligner
    import skew_aligner_pkg::*;
#(
    parameter int W        = DEFAULT_W,
    parameter int MAX_SKEW = DEFAULT_MAX_SKEW,
    parameter int SKW      = $clog2(MAX_SKEW + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   ref_in,
    input  logic [W-1:0]   dly_in,
    input  logic           start,
    output logic           busy,
    output logic           locked,
    output logic           err,
    output logic [SKW-1:0] skew,
    output logic [W-1:0]   aligned_ref,
    output logic [W-1:0]   aligned_dly,
    output logic           aligned_valid
);

    state_t         state;
    logic [SKW-1:0] cnt;
    logic [W-1:0]   probe;

    logic           lock_now;
    logic [SKW-1:0] lock_skew;
    logic [SKW-1:0] rd_skew;
    logic [W-1:0]   sel;

    // Lock decision for this cycle. A zero-skew hit is only possible on the
    // start cycle itself; during the search the probe is compared instead.
    always_comb begin
        lock_now  = 1'b0;
        lock_skew = skew;
        case (state)
            IDLE, LOCKED: begin
                if (start && (dly_in == ref_in)) begin
                    lock_now  = 1'b1;
                    lock_skew = '0;
                end
            end
            SEARCH: begin
                if (dly_in == probe) begin
                    lock_now  = 1'b1;
                    lock_skew = cnt;
                end
            end
            default: ;
        endcase
    end

    // Read the history with the skew being locked this cycle, so the pair
    // registered on the locking edge is already aligned.
    assign rd_skew = lock_now ? lock_skew : skew;

    ref_history #(
        .W        (W),
        .MAX_SKEW (MAX_SKEW),
        .SKW      (SKW)
    ) u_hist (
        .clk     (clk),
        .rst     (rst),
        .ref_in  (ref_in),
        .rd_skew (rd_skew),
        .rd_data (sel)
    );

    // Measurement FSM, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            probe         <= '0;
            skew          <= '0;
            busy          <= 1'b0;
            locked        <= 1'b0;
            aligned_valid <= 1'b0;
            err           <= 1'b0;
            aligned_ref   <= '0;
            aligned_dly   <= '0;
        end else begin
            err         <= 1'b0;
            aligned_ref <= sel;
            aligned_dly <= dly_in;
            case (state)
                IDLE, LOCKED: begin
                    if (start) begin
                        probe <= ref_in;
                        if (lock_now) begin
                            state         <= LOCKED;
                            skew          <= lock_skew;
                            busy          <= 1'b0;
                            locked        <= 1'b1;
                            aligned_valid <= 1'b1;
                        end else begin
                            state         <= SEARCH;
                            cnt           <= SKW'(1);
                            busy          <= 1'b1;
                            locked        <= 1'b0;
                            aligned_valid <= 1'b0;
                        end
                    end
`ifdef SKEW_ALIGNER_LOSS_DETECT_EN
                    // Skew is kept for debug when lock is lost
                    else if ((state == LOCKED) && (aligned_ref != aligned_dly)) begin
                        state         <= IDLE;
                        err           <= 1'b1;
                        locked        <= 1'b0;
                        aligned_valid <= 1'b0;
                    end
`endif
                end
                SEARCH: begin
                    if (lock_now) begin
                        state         <= LOCKED;
                        skew          <= lock_skew;
                        busy          <= 1'b0;
                        locked        <= 1'b1;
                        aligned_valid <= 1'b1;
                    end else if (cnt == SKW'(MAX_SKEW)) begin
                        state <= IDLE;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + SKW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_skew_aligner.sv
// ---------------------------------------------------------------------------
// tb_skew_aligner
// Directed bench for skew_aligner. The delayed stream is produced by the
// bench from its own record of past ref_in values (external delay ext_dly,
// -1 meaning dly_in held at 0). Expected aligned pairs are pushed to a
// scoreboard when a cycle is driven and popped after the clock edge.
// ---------------------------------------------------------------------------
module tb_skew_aligner;

    localparam int W        = 4;
    localparam int MAX_SKEW = 8;
    localparam int SKW      = $clog2(MAX_SKEW + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   ref_in;
    logic [W-1:0]   dly_in;
    logic           start;
    logic           busy;
    logic           locked;
    logic           err;
    logic [SKW-1:0] skew;
    logic [W-1:0]   aligned_ref;
    logic [W-1:0]   aligned_dly;
    logic           aligned_valid;

    skew_aligner #(
        .W        (W),
        .MAX_SKEW (MAX_SKEW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ref_in        (ref_in),
        .dly_in        (dly_in),
        .start         (start),
        .busy          (busy),
        .locked        (locked),
        .err           (err),
        .skew          (skew),
        .aligned_ref   (aligned_ref),
        .aligned_dly   (aligned_dly),
        .aligned_valid (aligned_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] d;
    } pair_t;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] rq[$];
    pair_t        sb[$];
    int           ext_dly  = 0;
    int           exp_skew = 0;
    bit           chk_pair = 1'b0;
    logic [W-1:0] gv = 4'd1;
    bit           seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stride-7 counter: no value repeats within 16 calls
    function automatic logic [W-1:0] gen();
        logic [W-1:0] v;
        v  = gv;
        gv = gv + 4'd7;
        return v;
    endfunction

    function automatic logic [W-1:0] past(input logic [W-1:0] r, input int k);
        if (k == 0) return r;
        if (k - 1 < rq.size()) return rq[k-1];
        return '0;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_busy"},   busy,          0);
        check({tag, "_locked"}, locked,        0);
        check({tag, "_err"},    err,           0);
        check({tag, "_skew"},   skew,          0);
        check({tag, "_aref"},   aligned_ref,   0);
        check({tag, "_adly"},   aligned_dly,   0);
        check({tag, "_avld"},   aligned_valid, 0);
    endtask

    // One clock cycle: drive, push expectation, clock, pop and compare
    task automatic cyc(input logic [W-1:0] r, input logic s);
        logic [W-1:0] d;
        pair_t        p;
        pair_t        e;
        d       = (ext_dly < 0) ? '0 : past(r, ext_dly);
        ref_in  = r;
        dly_in  = d;
        start   = s;
        p.r     = past(r, exp_skew);
        p.d     = d;
        sb.push_back(p);
        @(posedge clk);
        #1;
        start = 1'b0;
        rq.push_front(r);
        if (rq.size() > 16) void'(rq.pop_back());
        e = sb.pop_front();
        if (!rst) begin
            check("aligned_dly", aligned_dly, e.d);
            if (chk_pair) check("aligned_ref", aligned_ref, e.r);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        ref_in = '0;
        dly_in = '0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            ref_in = W'($urandom_range(15));
            dly_in = W'($urandom_range(15));
            start  = 1'($urandom_range(1));
            @(posedge clk);
            #1;
            check_zero("reset");
        end
        rst    = 1'b0;
        start  = 1'b0;
        ref_in = '0;
        dly_in = '0;
        check_zero("release");

        // Skew 0: dly_in tied to ref_in
        ext_dly  = 0;
        exp_skew = 0;
        cyc(gen(), 1'b0);
        cyc(gen(), 1'b0);
        chk_pair = 1'b1;
        cyc(gen(), 1'b1);
        check("s0_locked", locked, 1);
        check("s0_skew", skew, 0);
        check("s0_busy", busy, 0);
        check("s0_valid", aligned_valid, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(gen(), 1'b0);
            check("s0_busy_hold", busy, 0);
            check("s0_locked_hold", locked, 1);
        end

        // Skew 2: ref 5,9,3,... with start while ref_in = 5
        ext_dly  = 2;
        exp_skew = 2;
        chk_pair = 1'b0;
        cyc(4'd2, 1'b0);
        cyc(4'd4, 1'b0);
        cyc(4'd5, 1'b1);
        check("s2_e0_busy", busy, 1);
        check("s2_e0_locked", locked, 0);
        cyc(4'd9, 1'b0);
        check("s2_e1_busy", busy, 1);
        check("s2_e1_locked", locked, 0);
        chk_pair = 1'b1;
        cyc(4'd3, 1'b0);
        check("s2_e2_locked", locked, 1);
        check("s2_e2_skew", skew, 2);
        check("s2_e2_busy", busy, 0);
        check("s2_e2_valid", aligned_valid, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(gen(), 1'b0);
            check("s2_locked_hold", locked, 1);
        end

        // Timeout: dly_in held at 0, probe 7
        ext_dly  = -1;
        chk_pair = 1'b0;
        cyc(4'd7, 1'b1);
        check("to_e0_busy", busy, 1);
        check("to_e0_locked", locked, 0);
        for (int i = 1; i <= MAX_SKEW; i++) begin
            cyc(gen(), 1'b0);
            if (i < MAX_SKEW) begin
                check("to_busy", busy, 1);
                check("to_err_early", err, 0);
            end else begin
                check("to_end_busy", busy, 0);
                check("to_end_err", err, 1);
                check("to_end_locked", locked, 0);
                check("to_end_skew", skew, 2);
            end
        end
        cyc(gen(), 1'b0);
        check("to_err_pulse", err, 0);
        check("to_idle_busy", busy, 0);
        check("to_idle_locked", locked, 0);

        // Reset three cycles into a skew-5 search
        ext_dly  = 5;
        exp_skew = 5;
        for (int i = 0; i < 6; i++) cyc(gen(), 1'b0);
        cyc(gen(), 1'b1);
        check("mr_busy0", busy, 1);
        cyc(gen(), 1'b0);
        cyc(gen(), 1'b0);
        check("mr_busy2", busy, 1);
        rst = 1'b1;
        cyc(gen(), 1'b0);
        check_zero("midrst");
        rst = 1'b0;
        cyc(gen(), 1'b1);
        check("s5_e0_busy", busy, 1);
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) chk_pair = 1'b1;
            cyc(gen(), 1'b0);
            check("s5_err", err, 0);
            if (k < 5) begin
                check("s5_busy", busy, 1);
                check("s5_locked_early", locked, 0);
            end else begin
                check("s5_locked", locked, 1);
                check("s5_skew", skew, 5);
                check("s5_busy_end", busy, 0);
            end
        end
        for (int i = 0; i < 3; i++) cyc(gen(), 1'b0);

        // Lock at skew 1, then change the external delay to 2
        ext_dly  = 1;
        exp_skew = 1;
        chk_pair = 1'b0;
        cyc(gen(), 1'b1);
        check("s1_e0_busy", busy, 1);
        chk_pair = 1'b1;
        cyc(gen(), 1'b0);
        check("s1_locked", locked, 1);
        check("s1_skew", skew, 1);
        cyc(gen(), 1'b0);
        ext_dly  = 2;
        chk_pair = 1'b0;
`ifdef SKEW_ALIGNER_LOSS_DETECT_EN
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc(gen(), 1'b0);
            if (err) seen = 1'b1;
        end
        check("loss_err", seen, 1);
        check("loss_locked", locked, 0);
        check("loss_valid", aligned_valid, 0);
        check("loss_skew", skew, 1);
        cyc(gen(), 1'b0);
        check("loss_err_pulse", err, 0);
`else
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(gen(), 1'b0);
            check("noloss_locked", locked, 1);
            check("noloss_err", err, 0);
        end
        check("noloss_skew", skew, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
